// File: rtl/store_buffer.sv
// Store buffer between the MEM stage and a single-port data memory: posted
// stores drain in order, loads are checked against pending stores.
// Optional macro STORE_BUFFER_FWD_EN enables load forwarding from buffered stores.
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        st_valid_i,
  input  logic [31:0] st_addr_i,
  input  logic [31:0] st_data_i,
  output logic        st_ready_o,
  input  logic        ld_valid_i,
  input  logic [31:0] ld_addr_i,
  output logic        ld_ready_o,
  output logic [31:0] ld_data_o,
  output logic        empty_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        mem_write_o,
  output logic        mem_read_o,
  input  logic [31:0] mem_rdata_i
);

  // Handshakes: a store is taken on a rising edge when st_valid_i && st_ready_o;
  // a load completes in the cycle ld_valid_i && ld_ready_o (data on ld_data_o).
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [31:0]   addr_q [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [PW-1:0] head_q;
  logic [PW-1:0] tail_q;
  logic [CW-1:0] count_q;

  logic          full;
  logic          hit;
  logic [PW-1:0] slot_idx;
  logic          load_mem;
  logic          drain;
  logic          push;
`ifdef STORE_BUFFER_FWD_EN
  logic [PW-1:0] hit_idx;
  logic          fwd_hit;
`endif

  assign full = (count_q == FULL_CNT);

  // Walk oldest to youngest so the youngest matching entry is the last one kept.
  always_comb begin
    hit      = 1'b0;
    slot_idx = '0;
`ifdef STORE_BUFFER_FWD_EN
    hit_idx  = '0;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      slot_idx = head_q + PW'(i);
      if ((CW'(i) < count_q) && (addr_q[slot_idx] == ld_addr_i)) begin
        hit = 1'b1;
`ifdef STORE_BUFFER_FWD_EN
        hit_idx = slot_idx;
`endif
      end
    end
  end

  // Gating with rst_i keeps the memory port quiet while reset is held,
  // even before the first edge has cleared the pointers.
  assign load_mem = rst_i && ld_valid_i && !hit && !full;
  assign drain    = rst_i && (count_q != '0) && !load_mem;
  assign push     = rst_i && st_valid_i && !full;
`ifdef STORE_BUFFER_FWD_EN
  assign fwd_hit  = rst_i && ld_valid_i && hit;
`endif

  assign st_ready_o = !rst_i || !full;
  assign empty_o    = !rst_i || (count_q == '0);

  always_comb begin
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_write_o = 1'b0;
    mem_read_o  = 1'b0;
    ld_ready_o  = 1'b0;
    ld_data_o   = '0;
    if (load_mem) begin
      mem_read_o = 1'b1;
      mem_addr_o = ld_addr_i;
      ld_ready_o = 1'b1;
      ld_data_o  = mem_rdata_i;
    end else if (drain) begin
      mem_write_o = 1'b1;
      mem_addr_o  = addr_q[head_q];
      mem_wdata_o = data_q[head_q];
    end
`ifdef STORE_BUFFER_FWD_EN
    if (fwd_hit) begin
      ld_ready_o = 1'b1;
      ld_data_o  = data_q[hit_idx];
    end
`endif
  end

  // A full buffer refuses the store even if the head drains this cycle.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        addr_q[tail_q] <= st_addr_i;
        data_q[tail_q] <= st_data_i;
        tail_q         <= tail_q + 1'b1;
      end
      if (drain) begin
        head_q <= head_q + 1'b1;
      end
      count_q <= count_q + CW'(push) - CW'(drain);
    end
  end

endmodule
